// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: slot index, tag entry, widths.
// Slots 0..N_RD-1 are readers, slot N_RD is the single writer.
package ram_arb_pkg;
  localparam int N_RD = 3;
  localparam int AXI_WIDTH = 128;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int LSB = $clog2(AXI_WIDTH) - 3;
  localparam int AW = AXI_ADDR_WIDTH - LSB;
  localparam int NS = N_RD + 1;
  localparam int SW = $clog2(NS);

  typedef logic [SW-1:0] slot_t;

  typedef struct packed {
    logic  valid;
    slot_t idx;
  } tag_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_t;

  function automatic slot_t slot_inc(slot_t s);
    return (s == slot_t'(N_RD)) ? '0 : slot_t'(s + 1'b1);
  endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Cyclic first-set-bit search starting at ptr.
// Ports: req (per slot), ptr (start slot), win (index), found.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int N = NS
) (
  input  logic [N-1:0] req,
  input  slot_t        ptr,
  output slot_t        win,
  output logic         found
);
  always_comb begin
    int j;
    j = 0;
    win = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        win = slot_t'(j);
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among N_RD readers and one writer.
// Ports: rd_* reader side, wr_* writer side, mem_* RAM side, clk/rst.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_RD = ram_arb_pkg::N_RD,
  parameter int AXI_WIDTH = ram_arb_pkg::AXI_WIDTH,
  parameter int AXI_ADDR_WIDTH = ram_arb_pkg::AXI_ADDR_WIDTH,
  parameter int LSB = $clog2(AXI_WIDTH) - 3,
  parameter int MEM_LAT = 1,
  parameter int BURST = 8,
  localparam int AW = AXI_ADDR_WIDTH - LSB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD-1:0]        rd_req,
  input  logic [N_RD*AW-1:0]     rd_addr,
  output logic [N_RD-1:0]        rd_gnt,
  output logic [N_RD-1:0]        rd_valid,
  output logic [AXI_WIDTH-1:0]   rd_data,
  input  logic                   wr_req,
  input  logic [AW-1:0]          wr_addr,
  input  logic [AXI_WIDTH-1:0]   wr_data,
  input  logic [AXI_WIDTH/8-1:0] wr_strb,
  output logic                   wr_gnt,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [AXI_WIDTH-1:0]   mem_wdata,
  output logic [AXI_WIDTH/8-1:0] mem_strb,
  input  logic [AXI_WIDTH-1:0]   mem_rdata
);
  localparam int NSL = N_RD + 1;
  localparam int CW = $clog2(BURST + 1);

  logic [NSL-1:0] req;
  assign req = {wr_req, rd_req};

  arb_state_t state, nxt_state;
  slot_t owner, nxt_owner;
  slot_t rr_ptr, nxt_ptr;
  logic [CW-1:0] burst_cnt, nxt_cnt;

  slot_t p0_win, p1_win;
  logic  p0_found, p1_found;
  logic  go;
  slot_t win;
  logic  own_req, others;

  tag_t tags [MEM_LAT];
  tag_t last;

  // p0: fresh arbitration from rr_ptr; p1: arbitration past the owner
  rr_pick #(.N(NSL)) u_pick_ptr (
    .req   (req),
    .ptr   (rr_ptr),
    .win   (p0_win),
    .found (p0_found)
  );

  rr_pick #(.N(NSL)) u_pick_next (
    .req   (req),
    .ptr   (slot_inc(owner)),
    .win   (p1_win),
    .found (p1_found)
  );

  assign own_req = req[owner];
  assign others = |(req & ~(NSL'(1) << owner));

  always_comb begin
    go = 1'b0;
    win = '0;
    nxt_state = state;
    nxt_owner = owner;
    nxt_ptr = rr_ptr;
    nxt_cnt = burst_cnt;
    if (rst) begin
      go = 1'b0;
    end else if (state == ST_IDLE) begin
      if (p0_found) begin
        go = 1'b1;
        win = p0_win;
        nxt_state = ST_HOLD;
        nxt_owner = p0_win;
        nxt_cnt = CW'(1);
      end
    end else if (own_req && burst_cnt < CW'(BURST)) begin
      go = 1'b1;
      win = owner;
      nxt_cnt = burst_cnt + 1'b1;
    end else if (own_req && others) begin
      // burst exhausted with contention: hand over
      go = 1'b1;
      win = p1_win;
      nxt_ptr = slot_inc(owner);
      nxt_owner = p1_win;
      nxt_cnt = CW'(1);
    end else if (own_req) begin
      go = 1'b1;
      win = owner;
    end else begin
      // owner released: re-arbitrate without a bubble
      nxt_ptr = slot_inc(owner);
      if (p1_found) begin
        go = 1'b1;
        win = p1_win;
        nxt_owner = p1_win;
        nxt_cnt = CW'(1);
      end else begin
        nxt_state = ST_IDLE;
        nxt_cnt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
      rr_ptr <= '0;
      burst_cnt <= '0;
    end else begin
      state <= nxt_state;
      owner <= nxt_owner;
      rr_ptr <= nxt_ptr;
      burst_cnt <= nxt_cnt;
    end
  end

  always_comb begin
    rd_gnt = '0;
    mem_addr = '0;
    for (int p = 0; p < N_RD; p++) begin
      rd_gnt[p] = go && (win == slot_t'(p));
      if (rd_gnt[p]) mem_addr = rd_addr[p*AW +: AW];
    end
    wr_gnt = go && (win == slot_t'(N_RD));
    if (wr_gnt) mem_addr = wr_addr;
    mem_ren = |rd_gnt;
    mem_wen = wr_gnt;
    mem_wdata = wr_gnt ? wr_data : '0;
    mem_strb = wr_gnt ? wr_strb : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: mem_ren, idx: win};
      for (int i = 1; i < MEM_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  assign last = tags[MEM_LAT-1];

  always_comb begin
    for (int p = 0; p < N_RD; p++)
      rd_valid[p] = last.valid && !rst && (last.idx == slot_t'(p));
    rd_data = (|rd_valid) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic
// checked against a grant-order memory model and expected-return queue.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int W = AXI_WIDTH;
  localparam int SB = W / 8;
  localparam int LAT = 1;
  localparam int BST = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_RD-1:0]    rd_req;
  logic [N_RD*AW-1:0] rd_addr;
  logic [N_RD-1:0]    rd_gnt, rd_valid;
  logic [W-1:0]       rd_data;
  logic               wr_req, wr_gnt;
  logic [AW-1:0]      wr_addr;
  logic [W-1:0]       wr_data;
  logic [SB-1:0]      wr_strb;
  logic               mem_ren, mem_wen;
  logic [AW-1:0]      mem_addr;
  logic [W-1:0]       mem_wdata, mem_rdata;
  logic [SB-1:0]      mem_strb;

  ram_port_arbiter #(
    .N_RD(N_RD), .AXI_WIDTH(W), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .MEM_LAT(LAT), .BURST(BST)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_gnt(wr_gnt),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata)
  );

  function automatic logic [W-1:0] init_word(int i);
    return {SB{8'hA5}} ^ {(W/32){32'(i) ^ 32'h10}};
  endfunction

  // RAM with registered read (one-cycle latency); reloads on reset
  logic [W-1:0] ram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (mem_wen) begin
      for (int b = 0; b < SB; b++)
        if (mem_strb[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_ren) mem_rdata <= ram[mem_addr[5:0]];
    else mem_rdata <= {(W/32){$urandom}};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // reference model
  typedef struct {
    int port;
    logic [W-1:0] data;
    int due;
  } ret_t;

  logic [W-1:0] ref_mem [64];
  ret_t q[$];
  int gcnt [N_RD];
  int vcnt [N_RD];
  int cyc = 0;

  task automatic sample();
    ret_t r;
    int ng;
    ng = $countones(rd_gnt) + int'(wr_gnt);
    check("one_gnt", W'(ng <= 1), W'(1));
    check("one_en", W'(int'(mem_ren) + int'(mem_wen) <= 1), W'(1));
    check("gnt_no_req", W'({wr_gnt & ~wr_req, rd_gnt & ~rd_req}), '0);
    if (rd_valid != '0) begin
      check("rv_onehot", W'($onehot(rd_valid)), W'(1));
      if (q.size() == 0) begin
        check("rv_spurious", W'(rd_valid), '0);
      end else begin
        r = q.pop_front();
        check("rv_port", W'(rd_valid), W'(1) << r.port);
        check("rv_data", rd_data, r.data);
        check("rv_lat", W'(cyc), W'(r.due));
        for (int p = 0; p < N_RD; p++) if (rd_valid[p]) vcnt[p]++;
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      check("rv_missing", W'(rd_valid), W'(1) << r.port);
    end
    if (wr_gnt)
      for (int b = 0; b < SB; b++)
        if (wr_strb[b]) ref_mem[wr_addr[5:0]][8*b +: 8] = wr_data[8*b +: 8];
    for (int p = 0; p < N_RD; p++) begin
      if (rd_gnt[p]) begin
        r.port = p;
        r.data = ref_mem[rd_addr[p*AW +: 6]];
        r.due = cyc + LAT;
        q.push_back(r);
        gcnt[p]++;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    #1 sample();
    @(negedge clk);
  endtask

  task automatic set_rd(int p, logic r, int a);
    rd_req[p] = r;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic clear_reqs();
    rd_req = '0;
    wr_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    q.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_gnt", W'({wr_gnt, rd_gnt}), '0);
    check("rst_rv", W'(rd_valid), '0);
    check("rst_en", W'({mem_ren, mem_wen}), '0);
    check("rst_rdata", rd_data, '0);
    check("rst_bus", mem_wdata | W'(mem_addr) | W'(mem_strb), '0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(int n);
    clear_reqs();
    repeat (n) tick();
  endtask

  logic [W-1:0] wd, wexp, tmp;
  logic [N_RD:0] g;

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_strb = '0;
    clear_reqs();

    // single read, one-cycle return
    do_reset();
    set_rd(1, 1'b1, 'h10);
    #1 check("t1_gnt", W'(rd_gnt), W'(3'b010));
    check("t1_early", W'(rd_valid), '0);
    tick();
    set_rd(1, 1'b0, 'h10);
    #1 check("t1_valid", W'(rd_valid), W'(3'b010));
    check("t1_data", rd_data, {SB{8'hA5}});
    tick();
    #1 check("t1_quiet", W'(rd_valid), '0);
    drain(3);

    // all slots requesting: 8-beat bursts in slot order
    do_reset();
    for (int p = 0; p < N_RD; p++) set_rd(p, 1'b1, p + 1);
    wr_req = 1'b1;
    wr_addr = AW'(40);
    wr_data = {(W/32){$urandom}};
    wr_strb = SB'($urandom);
    for (int k = 0; k < 64; k++) begin
      #1 check("burst_seq", W'({wr_gnt, rd_gnt}), W'(1) << ((k / BST) % NS));
      tick();
    end
    drain(4);

    // owner drops: next requester granted with no bubble
    do_reset();
    set_rd(0, 1'b1, 3);
    set_rd(2, 1'b1, 7);
    for (int k = 0; k < 3; k++) begin
      #1 check("drop_p0", W'(rd_gnt), W'(3'b001));
      tick();
    end
    set_rd(0, 1'b0, 3);
    #1 check("drop_next", W'(rd_gnt), W'(3'b100));
    tick();
    set_rd(0, 1'b1, 3);
    #1 check("drop_hold", W'(rd_gnt), W'(3'b100));
    tick();
    drain(4);

    // partial write then read of same word
    do_reset();
    wd = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wr_req = 1'b1;
    wr_addr = AW'('h20);
    wr_data = wd;
    wr_strb = SB'(16'h00FF);
    #1 check("wr_gnt", W'(wr_gnt), W'(1));
    tick();
    wr_req = 1'b0;
    set_rd(0, 1'b1, 'h20);
    #1 check("raw_gnt", W'(rd_gnt), W'(3'b001));
    tick();
    set_rd(0, 1'b0, 'h20);
    tmp = init_word('h20);
    wexp = {tmp[W-1:64], wd[63:0]};
    #1 check("raw_data", rd_data, wexp);
    check("raw_valid", W'(rd_valid), W'(3'b001));
    tick();
    drain(3);

    // reset with a read in flight
    do_reset();
    set_rd(0, 1'b1, 5);
    #1 check("fl_gnt", W'(rd_gnt), W'(3'b001));
    tick();
    rst = 1'b1;
    clear_reqs();
    q.delete();
    #1 check("fl_rst_rv", W'(rd_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("fl_post_rv", W'(rd_valid), '0);
    @(negedge clk);
    set_rd(2, 1'b1, 9);
    set_rd(1, 1'b1, 8);
    wr_req = 1'b1;
    #1 check("fl_first", W'({wr_gnt, rd_gnt}), W'(4'b0010));
    tick();
    drain(4);

    // random traffic
    do_reset();
    for (int p = 0; p < N_RD; p++) begin
      gcnt[p] = 0;
      vcnt[p] = 0;
    end
    for (int k = 0; k < 10000; k++) begin
      for (int p = 0; p < N_RD; p++)
        if (!rd_req[p] && $urandom_range(1) == 1)
          set_rd(p, 1'b1, int'($urandom_range(63)));
      if (!wr_req && $urandom_range(1) == 1) begin
        wr_req = 1'b1;
        wr_addr = AW'($urandom_range(63));
        wr_data = {(W/32){$urandom}};
        wr_strb = SB'({$urandom, $urandom});
      end
      #1 check("work_cons", W'(|{wr_gnt, rd_gnt}), W'(|{wr_req, rd_req}));
      g = {wr_gnt, rd_gnt};
      tick();
      rd_req = rd_req & ~g[N_RD-1:0];
      if (g[N_RD]) wr_req = 1'b0;
    end
    drain(5);
    for (int p = 0; p < N_RD; p++)
      check($sformatf("cnt_p%0d", p), W'(vcnt[p]), W'(gcnt[p]));
    check("q_empty", W'(q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
